palindrome_detector: RTL and testbench
======================================

Name: palindrome_detector

Overview:
- Registered detector that reports whether an input word reads the same forwards and backwards.
- The word is treated as a sequence of SYM_WIDTH-bit symbols; the default SYM_WIDTH=1 gives bit-level palindrome detection.
- Sits in a streaming datapath and produces one result per accepted word with one-cycle latency, plus a count of mismatched symbol pairs for diagnostics.

Parameters:
- DATA_WIDTH, 8, width of data_in in bits; must be at least 1.
- SYM_WIDTH, 1, symbol granularity in bits; DATA_WIDTH must be a multiple of SYM_WIDTH (elaboration-time check, fatal if violated).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  data_in is valid this cycle.
- data_in  input  DATA_WIDTH  word under test; symbol 0 = bits [SYM_WIDTH-1:0].
- out_valid  output  1  result registers hold a fresh result this cycle.
- is_palindrome  output  1  1 when the word is symmetric at symbol granularity.
- mismatch_count  output  CW  number of unequal symbol pairs; CW = $clog2(NUM_SYM/2+1), minimum 1, where NUM_SYM = DATA_WIDTH/SYM_WIDTH.

Behaviour:
- Reset (asynchronous assert; release is sampled on clk): out_valid=0, is_palindrome=0, mismatch_count=0.
- Pair comparison: for i in 0..NUM_SYM/2-1, symbol i is compared with symbol NUM_SYM-1-i.
  - The comparison is on the whole symbol; bits within a symbol are not reversed.
- Middle symbol: when NUM_SYM is odd, the middle symbol is not compared.
- Output computation:
  - is_palindrome = (mismatch_count_next == 0).
  - mismatch_count_next = popcount of the per-pair mismatch vector.
- Single-symbol word (NUM_SYM==1): always a palindrome with count 0.
- Latency: exactly 1 cycle. When in_valid=1 at edge N, the results are visible after edge N with out_valid=1.
- in_valid=0 at an edge: out_valid goes to 0 and is_palindrome/mismatch_count hold their previous values.
- Throughput: one word per cycle. No backpressure and no ready signal.
- Reset asserted mid-stream: all outputs clear immediately, and any in-flight result is discarded.
- Structure: purely combinational compare/popcount feeding one register stage. No other state.
- X handling: data_in is don't-care when in_valid=0 and must not propagate to the outputs.

Decomposition:
- Package palindrome_pkg:
  - Function clog2-based count-width helper.
  - Function popcount over a parameterised vector.
- Sub-module palindrome_pair_cmp:
  - Parameters DATA_WIDTH and SYM_WIDTH.
  - Combinational; produces the NUM_SYM/2-bit mismatch vector.
  - The top level adds popcount and the output registers.

Test Plan:
- Reset with defaults (DATA_WIDTH=8, SYM_WIDTH=1): assert rst with in_valid=1 -> out_valid=0, is_palindrome=0, mismatch_count=0 held throughout reset.
- data_in=8'b10100101, in_valid=1 -> next cycle out_valid=1, is_palindrome=1, mismatch_count=0.
- data_in=8'b00010000 -> is_palindrome=0, mismatch_count=1 (bit4 vs bit3 differ).
- data_in=8'b10000001 followed by in_valid=0 -> first cycle is_palindrome=1, count=0; next cycle out_valid=0 with is_palindrome still 1.
- SYM_WIDTH=4: data_in=8'hAA -> is_palindrome=1. data_in=8'hA5 -> is_palindrome=0, count=1.
- DATA_WIDTH=5: data_in=5'b10x01 style sweep with middle bit 0/1 -> is_palindrome=1 for both. Also assert rst between back-to-back valid words -> outputs clear asynchronously and the word in flight is dropped.

Source files
------------

// File: rtl/palindrome_pkg.sv
// Shared helpers for the palindrome detector: count-width sizing and popcount.
// Pure functions, no state; used at elaboration time and in combinational logic.
// No flow control involved.
package palindrome_pkg;

  // Widest mismatch vector the popcount helper accepts.
  localparam int POP_MAX = 256;

  // Width needed to hold 0..num_sym/2 mismatched pairs, never less than one bit.
  function automatic int count_width(input int num_sym);
    int w;
    w = $clog2(num_sym / 2 + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Number of set bits; callers zero-extend narrower vectors to POP_MAX.
  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/palindrome_pair_cmp.sv
// Compares mirrored symbol pairs of a word and flags every unequal pair.
// Purely combinational, zero latency.
// No flow control; evaluates whatever is on data_i.
module palindrome_pair_cmp #(
  parameter int  DATA_WIDTH = 8,
  parameter int  SYM_WIDTH  = 1,
  localparam int NUM_SYM    = DATA_WIDTH / SYM_WIDTH,
  localparam int NUM_PAIRS  = NUM_SYM / 2,
  // A single-symbol word has no pairs; keep a one-bit vector tied low.
  localparam int PAIR_W     = (NUM_PAIRS < 1) ? 1 : NUM_PAIRS
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [PAIR_W-1:0]     mismatch_o
);

  // Symbol i against symbol NUM_SYM-1-i, whole symbols, middle symbol skipped.
  always_comb begin
    mismatch_o = '0;
    for (int i = 0; i < NUM_PAIRS; i++) begin
      mismatch_o[i] = (data_i[i*SYM_WIDTH +: SYM_WIDTH] !=
                       data_i[(NUM_SYM-1-i)*SYM_WIDTH +: SYM_WIDTH]);
    end
  end

endmodule

// File: rtl/palindrome_detector.sv
// Reports whether each accepted word is symmetric at symbol granularity, plus mismatch count.
// One-cycle latency: word sampled with in_valid at edge N, result valid after edge N.
// No backpressure; accepts one word per cycle, results hold while in_valid is low.
module palindrome_detector
  import palindrome_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  SYM_WIDTH  = 1,
  localparam int NUM_SYM    = DATA_WIDTH / SYM_WIDTH,
  localparam int NUM_PAIRS  = NUM_SYM / 2,
  localparam int PAIR_W     = (NUM_PAIRS < 1) ? 1 : NUM_PAIRS,
  localparam int CW         = count_width(NUM_SYM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  out_valid,
  output logic                  is_palindrome,
  output logic [CW-1:0]         mismatch_count
);

  // Reject configurations where the word does not split into whole symbols.
  if (DATA_WIDTH < 1 || SYM_WIDTH < 1 || (DATA_WIDTH % SYM_WIDTH) != 0) begin : g_bad_cfg
    $fatal(1, "palindrome_detector: DATA_WIDTH must be a positive multiple of SYM_WIDTH");
  end
  if (NUM_PAIRS > POP_MAX) begin : g_too_wide
    $fatal(1, "palindrome_detector: too many symbol pairs for popcount helper");
  end

  logic [PAIR_W-1:0] mismatch_vec;
  logic [CW-1:0]     cnt_d;
  logic              pal_d;
  logic              vld_q;
  logic              pal_q;
  logic [CW-1:0]     cnt_q;

  palindrome_pair_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .SYM_WIDTH  (SYM_WIDTH)
  ) u_pair_cmp (
    .data_i     (data_in),
    .mismatch_o (mismatch_vec)
  );

  // Count unequal pairs; a word is a palindrome exactly when none differ.
  always_comb begin
    cnt_d = CW'(popcount(POP_MAX'(mismatch_vec)));
    pal_d = (cnt_d == '0);
  end

  // Single result stage; results only load on a valid word so idle data never leaks out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      pal_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        pal_q <= pal_d;
        cnt_q <= cnt_d;
      end
    end
  end

  assign out_valid      = vld_q;
  assign is_palindrome  = pal_q;
  assign mismatch_count = cnt_q;

endmodule

// File: tb/tb_palindrome_detector.sv
// Scoreboard bench for palindrome_detector across three configurations.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
// Instances: 0 = (8,1), 1 = (8,4), 2 = (5,1).
module tb_palindrome_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid [3];
  logic [7:0] din      [3];
  logic       ov       [3];
  logic       pal      [3];
  logic [2:0] cnt      [3];

  logic       ov0, ov1, ov2, pal0, pal1, pal2;
  logic [2:0] c0;
  logic [0:0] c1;
  logic [1:0] c2;

  palindrome_detector #(.DATA_WIDTH(8), .SYM_WIDTH(1)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .data_in(din[0]),
    .out_valid(ov0), .is_palindrome(pal0), .mismatch_count(c0));

  palindrome_detector #(.DATA_WIDTH(8), .SYM_WIDTH(4)) u_d8s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .data_in(din[1]),
    .out_valid(ov1), .is_palindrome(pal1), .mismatch_count(c1));

  palindrome_detector #(.DATA_WIDTH(5), .SYM_WIDTH(1)) u_d5 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .data_in(din[2][4:0]),
    .out_valid(ov2), .is_palindrome(pal2), .mismatch_count(c2));

  assign ov[0]  = ov0;
  assign ov[1]  = ov1;
  assign ov[2]  = ov2;
  assign pal[0] = pal0;
  assign pal[1] = pal1;
  assign pal[2] = pal2;
  assign cnt[0] = c0;
  assign cnt[1] = {2'b00, c1};
  assign cnt[2] = {1'b0, c2};

  typedef struct packed {
    logic       v;
    logic       p;
    logic [2:0] c;
  } exp_t;

  exp_t       exp_q  [3][$];
  logic       hold_p [3];
  logic [2:0] hold_c [3];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0d expected %0d", name, k, act, expv);
    end
  endtask

  // Expected results after an edge where instance k (or none, k<0) takes a word.
  task automatic push_edge(input int k, input logic [7:0] d_unused, input bit p, input int c);
    exp_t e;
    for (int j = 0; j < 3; j++) begin
      if (j == k) begin
        hold_p[j] = p;
        hold_c[j] = 3'(c);
        e = '{v: 1'b1, p: p, c: 3'(c)};
      end else begin
        e = '{v: 1'b0, p: hold_p[j], c: hold_c[j]};
      end
      exp_q[j].push_back(e);
    end
  endtask

  task automatic push_reset();
    for (int j = 0; j < 3; j++) begin
      hold_p[j] = 1'b0;
      hold_c[j] = 3'd0;
      exp_q[j].push_back('{v: 1'b0, p: 1'b0, c: 3'd0});
    end
  endtask

  // Present one word to instance k (k<0: all idle); idle instances see X data.
  task automatic drive(input int k, input logic [7:0] d, input bit p, input int c);
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      in_valid[j] = (j == k);
      din[j]      = (j == k) ? d : 8'bx;
    end
    @(posedge clk);
    push_edge(k, d, p, c);
  endtask

  task automatic check_cleared(input int k, input string name);
    check({name, "_vld"}, k, ov[k], 0);
    check({name, "_pal"}, k, pal[k], 0);
    check({name, "_cnt"}, k, cnt[k], 0);
  endtask

  // Monitor: compare every presented output cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (exp_q[k].size() != 0) begin
          e = exp_q[k].pop_front();
          check("out_valid", k, ov[k], e.v);
          check("is_palindrome", k, pal[k], e.p);
          check("mismatch_count", k, cnt[k], e.c);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with a valid word on the input: nothing may be captured.
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_valid[j] = 1'b1;
      din[j]      = 8'hA5;
    end
    #1;
    for (int j = 0; j < 3; j++) check_cleared(j, "reset");
    repeat (3) begin
      @(posedge clk);
      push_reset();
    end
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 3; j++) in_valid[j] = 1'b0;
    @(posedge clk);
    push_edge(-1, 8'h00, 1'b0, 0);

    // DATA_WIDTH=8, SYM_WIDTH=1
    drive(0, 8'b10100101, 1, 0);
    drive(0, 8'b00010000, 0, 1);
    drive(0, 8'b10000001, 1, 0);
    drive(-1, 8'h00, 0, 0);          // out_valid drops, result held
    drive(0, 8'b11110000, 0, 4);
    drive(0, 8'b01101001, 0, 4);
    drive(0, 8'b00000011, 0, 2);
    drive(0, 8'b00011000, 1, 0);
    drive(-1, 8'h00, 0, 0);

    // DATA_WIDTH=8, SYM_WIDTH=4: nibbles compared whole, not bit-reversed
    drive(1, 8'hAA, 1, 0);
    drive(1, 8'hA5, 0, 1);
    drive(1, 8'h00, 1, 0);
    drive(1, 8'h5A, 0, 1);
    drive(-1, 8'h00, 0, 0);

    // DATA_WIDTH=5: middle bit ignored
    drive(2, 8'b10001, 1, 0);
    drive(2, 8'b10101, 1, 0);
    drive(2, 8'b10000, 0, 1);
    drive(2, 8'b11000, 0, 2);
    drive(2, 8'b00100, 1, 0);
    drive(2, 8'b01110, 1, 0);

    // Reset lands while the next word is waiting for its edge.
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      in_valid[j] = (j == 2);
      din[j]      = (j == 2) ? 8'b00011 : 8'bx;
    end
    #2 rst = 1'b1;
    #1;
    check_cleared(2, "async_rst");
    @(posedge clk);
    push_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 3; j++) in_valid[j] = 1'b0;
    @(posedge clk);
    push_edge(-1, 8'h00, 1'b0, 0);

    // Recovery after reset
    drive(0, 8'b01000010, 1, 0);
    drive(2, 8'b00001, 0, 1);
    drive(-1, 8'h00, 0, 0);
    drive(-1, 8'h00, 0, 0);

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) check("scoreboard_drain", k, exp_q[k].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
